vga_sync_to_count: RTL and testbench
====================================

Name: vga_sync_to_count

Overview:
- Receive-side counterpart of the VGA timing generator: takes incoming HSync/VSync pulses and reconstructs pixel column/row counts aligned to the source timing.
- Runs a lock state machine that qualifies line and frame timing, and flags timing errors.
- Sits between a sync source (generator, or an external capture path in the same clock domain) and the downstream pixel/pattern logic.

Parameters:
- TOTAL_COLS, 800, clocks per line.
- TOTAL_ROWS, 525, lines per frame.
- ACTIVE_COLS, 640, visible columns.
- ACTIVE_ROWS, 480, visible rows.
- H_SYNC_START, 656, column at which HSync asserts.
- V_SYNC_START, 490, row at which VSync asserts.
- LOCK_LINES, 4, consecutive good lines required before frame alignment.
- SYNC_ACTIVE_HIGH, 0, 0 = syncs asserted low; 1 = asserted high.

Ports:
- i_Clk, in, 1, pixel clock (25 MHz at defaults).
- i_Rst_L, in, 1, asynchronous active-low reset.
- i_HSync, in, 1, incoming horizontal sync, synchronous to i_Clk.
- i_VSync, in, 1, incoming vertical sync, synchronous to i_Clk.
- o_HSync, out, 1, i_HSync delayed 1 clock; aligned with the counts.
- o_VSync, out, 1, i_VSync delayed 1 clock.
- o_Col_Count, out, 10, reconstructed column, 0..TOTAL_COLS-1.
- o_Row_Count, out, 10, reconstructed row, 0..TOTAL_ROWS-1.
- o_Active, out, 1, o_Locked && col<ACTIVE_COLS && row<ACTIVE_ROWS.
- o_Locked, out, 1, timing qualified.
- o_Err, out, 1, one-clock pulse on loss of lock.

Behaviour:
- Reset (async, i_Rst_L=0): counts=0, o_Locked=0, o_Err=0, o_Active=0, o_HSync/o_VSync = deasserted level, previous-sync registers = deasserted, good-line count=0, state=SEARCH. Takes effect immediately, without a clock edge, including mid-frame.
- All outputs are registered. Latency is 1 clock from input to output.
- Edge detection: an H edge occurs on the sampling edge where i_HSync is asserted and its previous registered value was deasserted. A V edge is detected the same way on i_VSync.
- Column counter:
  - H edge: load H_SYNC_START.
  - Otherwise: increment, wrapping from TOTAL_COLS-1 to 0.
- Row counter:
  - V edge: load V_SYNC_START. This overrides any wrap increment in the same cycle.
  - Otherwise, on column wrap: increment, wrapping from TOTAL_ROWS-1 to 0.
  - A simultaneous H edge and V edge are applied independently.
- Event classification, using pre-update counts:
  - Good line: H edge with col==H_SYNC_START-1.
  - Bad line: H edge at any other col, or col==H_SYNC_START-1 with no H edge (missed pulse).
  - Good frame: V edge with row==V_SYNC_START-1 and col==TOTAL_COLS-1.
  - Bad frame: V edge at any other position, or that position reached with no V edge.
- FSM:
  - SEARCH:
    - Good line: good-line count +1.
    - Bad line or bad frame: count=0.
    - Count reaches LOCK_LINES: go to H_LOCK.
    - V events are otherwise ignored.
  - H_LOCK:
    - Good frame: go to LOCKED. o_Locked=1 from the next cycle.
    - Bad line or bad frame: go to SEARCH, count=0. No o_Err.
  - LOCKED:
    - Bad line or bad frame: go to SEARCH, count=0, o_Locked=0, and o_Err=1 for exactly 1 clock, all on the same edge.
    - Good events: stay.
- Counters keep running (free-wheel plus reload) in every state. Only o_Active/o_Locked are gated.
- Widths: internal compares are on 10-bit counts. The good-line counter is clog2(LOCK_LINES+1) bits and saturates.

Test Plan:
- Reset, then standard 800x525 stimulus (HSync low at col 656–751, VSync low at rows 490–491) → no lock on the first H edge (col≠655). Then:
  - H_LOCK after 4 further good edges.
  - o_Locked=1 one clock after the first good V edge.
  - o_Active first high with counts (0,0).
- Locked alignment → the cycle after i_HSync is first sampled low, o_Col_Count=656 and o_HSync=0. o_Row_Count=490 the cycle after the VSync fall.
- While locked, suppress one HSync pulse → when col==655 with no edge: o_Err pulses 1 clock, o_Locked=0 next cycle. Relocks after 4 good lines plus the next good VSync.
- While locked, one line of 801 clocks (H edge at col 656) → bad line, o_Err pulse, state SEARCH. Counts reload to 656.
- Drive i_Rst_L low mid-line at col 300 → all outputs reset immediately (no clock edge). Relock sequence as in scenario 1.
- SYNC_ACTIVE_HIGH=1 with inverted stimulus → lock timing identical to scenario 1. o_HSync/o_VSync reset to 0.

Source files
------------

// File: rtl/vga_sync_to_count.sv
// Rebuilds column/row counts from incoming HSync/VSync and qualifies lock.
// Latency: 1 clock from sync inputs to every output.
// Backpressure: none; consumes one sync sample per clock.
module vga_sync_to_count #(
  parameter int TOTAL_COLS       = 800,
  parameter int TOTAL_ROWS       = 525,
  parameter int ACTIVE_COLS      = 640,
  parameter int ACTIVE_ROWS      = 480,
  parameter int H_SYNC_START     = 656,
  parameter int V_SYNC_START     = 490,
  parameter int LOCK_LINES       = 4,
  parameter int SYNC_ACTIVE_HIGH = 0
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_HSync,
  input  logic       i_VSync,
  output logic       o_HSync,
  output logic       o_VSync,
  output logic [9:0] o_Col_Count,
  output logic [9:0] o_Row_Count,
  output logic       o_Active,
  output logic       o_Locked,
  output logic       o_Err
);

  localparam logic       ASSERT_LVL = (SYNC_ACTIVE_HIGH != 0);
  localparam int         CNT_W      = $clog2(LOCK_LINES + 1);
  localparam logic [9:0] HS_LOAD    = 10'(H_SYNC_START);
  localparam logic [9:0] HS_PRE     = 10'(H_SYNC_START - 1);
  localparam logic [9:0] VS_LOAD    = 10'(V_SYNC_START);
  localparam logic [9:0] VS_PRE     = 10'(V_SYNC_START - 1);
  localparam logic [9:0] COL_LAST   = 10'(TOTAL_COLS - 1);
  localparam logic [9:0] ROW_LAST   = 10'(TOTAL_ROWS - 1);
  localparam logic [9:0] ACT_C      = 10'(ACTIVE_COLS);
  localparam logic [9:0] ACT_R      = 10'(ACTIVE_ROWS);
  localparam logic [CNT_W-1:0] LOCK_N  = CNT_W'(LOCK_LINES);
  localparam logic [CNT_W-1:0] LOCK_M1 = CNT_W'(LOCK_LINES - 1);

  typedef enum logic [1:0] {SEARCH, H_LOCK, LOCKED} state_t;

  state_t           state_q;
  logic             hs_q, vs_q;
  logic [9:0]       col_q, col_d, row_q, row_d;
  logic [CNT_W-1:0] good_q;
  logic             locked_q, err_q, active_q;

  logic h_edge, v_edge, at_h, at_v;
  logic good_line, good_frame, bad_evt, locked_nxt;

  assign h_edge = (i_HSync == ASSERT_LVL) && (hs_q != ASSERT_LVL);
  assign v_edge = (i_VSync == ASSERT_LVL) && (vs_q != ASSERT_LVL);

  // Classification uses the counts before this clock's update.
  assign at_h       = (col_q == HS_PRE);
  assign at_v       = (row_q == VS_PRE) && (col_q == COL_LAST);
  assign good_line  = h_edge && at_h;
  assign good_frame = v_edge && at_v;
  assign bad_evt    = (h_edge != at_h) || (v_edge != at_v);
  assign locked_nxt = !bad_evt &&
                      ((state_q == LOCKED) || ((state_q == H_LOCK) && good_frame));

  always_comb begin
    col_d = (col_q == COL_LAST) ? 10'd0 : col_q + 10'd1;
    row_d = row_q;
    if (h_edge) begin
      col_d = HS_LOAD;
    end else if (col_q == COL_LAST) begin
      row_d = (row_q == ROW_LAST) ? 10'd0 : row_q + 10'd1;
    end
    if (v_edge) begin
      row_d = VS_LOAD;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      hs_q  <= ~ASSERT_LVL;
      vs_q  <= ~ASSERT_LVL;
      col_q <= '0;
      row_q <= '0;
    end else begin
      hs_q  <= i_HSync;
      vs_q  <= i_VSync;
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q  <= SEARCH;
      good_q   <= '0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      active_q <= 1'b0;
    end else begin
      err_q    <= 1'b0;
      locked_q <= locked_nxt;
      active_q <= locked_nxt && (col_d < ACT_C) && (row_d < ACT_R);
      case (state_q)
        SEARCH: begin
          if (bad_evt) begin
            good_q <= '0;
          end else if (good_line) begin
            if (good_q != LOCK_N) good_q <= good_q + 1'b1;
            if (good_q >= LOCK_M1) state_q <= H_LOCK;
          end
        end
        H_LOCK: begin
          if (bad_evt) begin
            state_q <= SEARCH;
            good_q  <= '0;
          end else if (good_frame) begin
            state_q <= LOCKED;
          end
        end
        LOCKED: begin
          if (bad_evt) begin
            state_q <= SEARCH;
            good_q  <= '0;
            err_q   <= 1'b1;
          end
        end
        default: state_q <= SEARCH;
      endcase
    end
  end

  assign o_HSync     = hs_q;
  assign o_VSync     = vs_q;
  assign o_Col_Count = col_q;
  assign o_Row_Count = row_q;
  assign o_Active    = active_q;
  assign o_Locked    = locked_q;
  assign o_Err       = err_q;

endmodule

// File: tb/tb_vga_sync_to_count.sv
// Drives a shrunken video timing into active-low and active-high instances
// and checks both against a behavioural lock/count model every clock.
module tb_vga_sync_to_count;
  localparam int TC = 20, TR = 12, AC = 12, AR = 8, HS = 14, VS = 9, LL = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic h0, v0, h1, v1;
  logic       ohs0, ovs0, act0, lock0, err0;
  logic       ohs1, ovs1, act1, lock1, err1;
  logic [9:0] col0, row0, col1, row1;

  always #5 clk = ~clk;

  vga_sync_to_count #(.TOTAL_COLS(TC), .TOTAL_ROWS(TR), .ACTIVE_COLS(AC), .ACTIVE_ROWS(AR),
    .H_SYNC_START(HS), .V_SYNC_START(VS), .LOCK_LINES(LL), .SYNC_ACTIVE_HIGH(0)) dut_lo (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_HSync(h0), .i_VSync(v0),
    .o_HSync(ohs0), .o_VSync(ovs0), .o_Col_Count(col0), .o_Row_Count(row0),
    .o_Active(act0), .o_Locked(lock0), .o_Err(err0));

  vga_sync_to_count #(.TOTAL_COLS(TC), .TOTAL_ROWS(TR), .ACTIVE_COLS(AC), .ACTIVE_ROWS(AR),
    .H_SYNC_START(HS), .V_SYNC_START(VS), .LOCK_LINES(LL), .SYNC_ACTIVE_HIGH(1)) dut_hi (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_HSync(h1), .i_VSync(v1),
    .o_HSync(ohs1), .o_VSync(ovs1), .o_Col_Count(col1), .o_Row_Count(row1),
    .o_Active(act1), .o_Locked(lock1), .o_Err(err1));

  int tests = 0, fails = 0;
  int m_col, m_row, m_good, m_phase;   // phase: 0 searching, 1 line-locked, 2 locked
  bit m_hp, m_vp, m_err, m_lock, m_act;
  int samp, first_lock, first_act, lock_col, lock_row, err_cnt, srow;
  bit prev_ohs0, prev_ovs0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, samp);
    end
  endtask

  task automatic model_reset();
    m_col = 0; m_row = 0; m_good = 0; m_phase = 0;
    m_hp = 0; m_vp = 0; m_err = 0; m_lock = 0; m_act = 0;
  endtask

  // h/v are the asserted-ness of the syncs sampled on the coming edge.
  task automatic model_step(input bit h, input bit v);
    bit he, ve, on_h, on_v, bad;
    he   = h && !m_hp;
    ve   = v && !m_vp;
    on_h = (m_col == HS - 1);
    on_v = (m_row == VS - 1) && (m_col == TC - 1);
    bad  = (he != on_h) || (ve != on_v);
    m_err = 0;
    if (bad) begin
      m_err = (m_phase == 2);
      m_phase = 0;
      m_good = 0;
    end else if (m_phase == 0 && he) begin
      m_good = (m_good < LL) ? m_good + 1 : LL;
      if (m_good >= LL) m_phase = 1;
    end else if (m_phase == 1 && ve) begin
      m_phase = 2;
    end
    if (ve) m_row = VS;
    else if (!he && m_col == TC - 1) m_row = (m_row + 1) % TR;
    m_col = he ? HS : (m_col + 1) % TC;
    m_hp = h; m_vp = v;
    m_lock = (m_phase == 2);
    m_act  = m_lock && (m_col < AC) && (m_row < AR);
  endtask

  task automatic check_outputs();
    chk("lo col",    int'(col0),  m_col);
    chk("lo row",    int'(row0),  m_row);
    chk("lo locked", int'(lock0), int'(m_lock));
    chk("lo err",    int'(err0),  int'(m_err));
    chk("lo active", int'(act0),  int'(m_act));
    chk("lo hsync",  int'(ohs0),  int'(!m_hp));
    chk("lo vsync",  int'(ovs0),  int'(!m_vp));
    chk("hi col",    int'(col1),  m_col);
    chk("hi row",    int'(row1),  m_row);
    chk("hi locked", int'(lock1), int'(m_lock));
    chk("hi err",    int'(err1),  int'(m_err));
    chk("hi active", int'(act1),  int'(m_act));
    chk("hi hsync",  int'(ohs1),  int'(m_hp));
    chk("hi vsync",  int'(ovs1),  int'(m_vp));
  endtask

  task automatic cycle(input bit h, input bit v);
    h0 = ~h; v0 = ~v; h1 = h; v1 = v;
    model_step(h, v);
    @(negedge clk);
    samp++;
    check_outputs();
    if (lock0 && first_lock < 0) begin
      first_lock = samp; lock_col = int'(col0); lock_row = int'(row0);
    end
    if (act0 && first_act < 0) first_act = samp;
    if (err0) err_cnt++;
    if (lock0 && prev_ohs0 && !ohs0) chk("aligned hsync col", int'(col0), HS);
    if (lock0 && prev_ovs0 && !ovs0) begin
      chk("aligned vsync row", int'(row0), VS);
      chk("aligned vsync col", int'(col0), 0);
    end
    prev_ohs0 = ohs0; prev_ovs0 = ovs0;
  endtask

  task automatic reset_now();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst col",     int'(col0),  0);
    chk("rst row",     int'(row0),  0);
    chk("rst locked",  int'(lock0), 0);
    chk("rst err",     int'(err0),  0);
    chk("rst active",  int'(act0),  0);
    chk("rst lo hs",   int'(ohs0),  1);
    chk("rst lo vs",   int'(ovs0),  1);
    chk("rst hi hs",   int'(ohs1),  0);
    chk("rst hi vs",   int'(ovs1),  0);
    chk("rst hi lock", int'(lock1), 0);
    @(negedge clk);
    rst_n = 1'b1;
    prev_ohs0 = 1'b1; prev_ovs0 = 1'b1;
  endtask

  task automatic src_line(input int len, input bit drop, input int shift, input int rst_col);
    for (int c = 0; c < len; c++) begin
      if (c == rst_col) reset_now();
      cycle(!drop && c >= HS + shift && c < HS + shift + 3, srow >= VS && srow < VS + 2);
    end
    srow = (srow + 1) % TR;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n * TR; i++) src_line(TC, 1'b0, 0, -1);
  endtask

  initial begin
    rst_n = 1'b0; h0 = 1'b1; v0 = 1'b1; h1 = 1'b0; v1 = 1'b0;
    srow = 0; samp = 0; first_lock = -1; first_act = -1; err_cnt = 0;
    lock_col = -1; lock_row = -1;
    @(negedge clk);
    reset_now();
    samp = 0;

    // Clean timing from reset: first edge misaligned, then 4 good lines and a good VSync.
    frames(2);
    chk("first lock cycle", first_lock, 181);
    chk("lock row", lock_row, VS);
    chk("lock col", lock_col, 0);
    chk("first active cycle", first_act, 241);

    // One HSync pulse missing while locked.
    err_cnt = 0;
    src_line(TC, 1'b0, 0, -1);
    src_line(TC, 1'b1, 0, -1);
    chk("drop err pulses", err_cnt, 1);
    chk("drop unlocked", int'(lock0), 0);
    frames(2);
    chk("drop relocked", int'(lock0), 1);

    // One line a clock too long while locked.
    err_cnt = 0;
    src_line(TC + 1, 1'b0, 0, -1);
    src_line(TC, 1'b0, 0, -1);
    chk("long line err pulses", err_cnt, 1);
    chk("long line unlocked", int'(lock0), 0);
    frames(2);
    chk("long line relocked", int'(lock0), 1);

    // Asynchronous reset in the middle of a line.
    src_line(TC, 1'b0, 0, 7);
    frames(2);
    chk("reset relocked", int'(lock0), 1);

    // Randomly disturbed timing, then pure noise, then recovery.
    for (int i = 0; i < 60; i++) begin
      int len, sh;
      bit dr;
      len = ($urandom_range(0, 9) == 0) ? TC - 1 + int'($urandom_range(0, 2)) : TC;
      dr  = ($urandom_range(0, 11) == 0);
      sh  = ($urandom_range(0, 14) == 0) ? int'($urandom_range(0, 2)) - 1 : 0;
      src_line(len, dr, sh, -1);
    end
    for (int i = 0; i < 200; i++) cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    srow = 0;
    src_line(TC, 1'b0, 0, -1);
    frames(2);
    chk("random relocked", int'(lock0), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
